// File: rtl/mem_if_pkg.sv
// Shared constants and state encoding for the cache <-> main memory link.
// The data cache reuses the width constants so both sides of the link agree.
package mem_if_pkg;

  localparam int ADDR_WIDTH           = 28;   // block address, byte address [31:4]
  localparam int BLOCK_WIDTH          = 128;  // one line = 4 words
  localparam int DEFAULT_LATENCY      = 5;
  localparam int DEFAULT_DEPTH_BLOCKS = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_main_memory_if.sv
// Cache-to-main-memory line interface.
//   master (cache)  : drives READ, WRITE, ADDRESS, WRITE_DATA
//   slave  (memory) : drives READ_DATA, BUSY_WAIT
// Handshake: READ/WRITE are levels held by the master until BUSY_WAIT is low
// in a cycle; that low cycle is the completion cycle, and READ_DATA is valid
// only then for a read.
interface data_main_memory_if #(
  parameter int ADDR_WIDTH  = mem_if_pkg::ADDR_WIDTH,
  parameter int BLOCK_WIDTH = mem_if_pkg::BLOCK_WIDTH
);
  logic                   READ;
  logic                   WRITE;
  logic [ADDR_WIDTH-1:0]  ADDRESS;
  logic [BLOCK_WIDTH-1:0] WRITE_DATA;
  logic [BLOCK_WIDTH-1:0] READ_DATA;
  logic                   BUSY_WAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITE_DATA,
    input  READ_DATA, BUSY_WAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITE_DATA,
    output READ_DATA, BUSY_WAIT
  );
endinterface

// File: rtl/data_mem_array.sv
// Line storage: DEPTH x WIDTH, single port, synchronous write, asynchronous
// read of the indexed line.
//   CLK   : clock
//   we    : write enable, stores wdata into line idx on the rising edge
//   idx   : line index (shared by read and write)
//   wdata : line to store
//   rdata : line currently at idx
// Contents start at zero in simulation and are never cleared by reset.
module data_mem_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] store [DEPTH] = '{default: '0};

  always_ff @(posedge CLK) begin
    if (we) store[idx] <= wdata;
  end

  assign rdata = store[idx];

endmodule

// File: rtl/data_main_memory.sv
// Block-addressed main data memory, responder to the data cache.
//   CLK       : clock
//   RESET     : synchronous active-high reset
//   mem       : slave side of data_main_memory_if (READ/WRITE/ADDRESS/
//               WRITE_DATA in, READ_DATA/BUSY_WAIT out)
//   state_dbg : current controller state
// A request seen in IDLE is captured, held in ACCESS for LATENCY edges, then
// completes in DONE (BUSY_WAIT low for one cycle) before returning to IDLE.
module data_main_memory
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH   = mem_if_pkg::ADDR_WIDTH,
  parameter int BLOCK_WIDTH  = mem_if_pkg::BLOCK_WIDTH,
  parameter int DEPTH_BLOCKS = DEFAULT_DEPTH_BLOCKS,
  parameter int LATENCY      = DEFAULT_LATENCY
) (
  input  logic               CLK,
  input  logic               RESET,
  data_main_memory_if.slave  mem,
  output mem_state_e         state_dbg
);

  localparam int IDX_W = $clog2(DEPTH_BLOCKS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  mem_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   op_write_q;
  logic [IDX_W-1:0]       idx_q;
  logic [BLOCK_WIDTH-1:0] wdata_q;
  logic [BLOCK_WIDTH-1:0] rdata_q;
  logic [BLOCK_WIDTH-1:0] arr_rdata;
  logic                   rd_req, wr_req, any_req;
  logic                   last_cycle, arr_we;
  logic                   unused_addr_bits;

  // X/Z on the request lines (initiator not yet reset) is treated as idle.
  assign rd_req  = (mem.READ === 1'b1);
  assign wr_req  = (mem.WRITE === 1'b1);
  assign any_req = rd_req | wr_req;

  // Upper address bits alias: only the low IDX_W bits select a line.
  assign unused_addr_bits = ^mem.ADDRESS[ADDR_WIDTH-1:IDX_W];

  assign last_cycle = (state_q == ACCESS) && (cnt_q == CNT_W'(LATENCY));
  // RESET on the final edge aborts the write, leaving the line untouched.
  assign arr_we     = last_cycle && op_write_q && !RESET;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == CNT_W'(LATENCY)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the stall is combinational in IDLE so the initiator sees it in
  // the same cycle it raises a request.
  always_comb begin
    mem.BUSY_WAIT = 1'b0;
    if (!RESET) begin
      case (state_q)
        IDLE:    mem.BUSY_WAIT = any_req;
        ACCESS:  mem.BUSY_WAIT = 1'b1;
        DONE:    mem.BUSY_WAIT = 1'b0;
        default: mem.BUSY_WAIT = 1'b0;
      endcase
    end
  end

  // Capture registers, latency counter and read data register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        cnt_q      <= CNT_W'(1);
        op_write_q <= wr_req;  // WRITE wins when both are high
        idx_q      <= mem.ADDRESS[IDX_W-1:0];
        wdata_q    <= mem.WRITE_DATA;
      end else if (state_q == ACCESS && !last_cycle) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == DONE) begin
        cnt_q <= '0;
      end
      if (last_cycle && !op_write_q) rdata_q <= arr_rdata;
    end
  end

  assign mem.READ_DATA = rdata_q;
  assign state_dbg     = state_q;

  data_mem_array #(
    .DEPTH (DEPTH_BLOCKS),
    .WIDTH (BLOCK_WIDTH)
  ) u_array (
    .CLK   (CLK),
    .we    (arr_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_data_main_memory.sv
// Directed bench for data_main_memory (LATENCY=5, DEPTH_BLOCKS=256).
module tb_data_main_memory;
  import mem_if_pkg::*;

  localparam int LAT = 5;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RESET;
  mem_state_e state_dbg;

  always #5 CLK = ~CLK;

  data_main_memory_if bus ();

  data_main_memory #(
    .DEPTH_BLOCKS (256),
    .LATENCY      (LAT)
  ) u_dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .mem       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks_total  = 0;
  int checks_passed = 0;
  logic [BLOCK_WIDTH-1:0] exp_q[$];

  localparam logic [127:0] D1  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D2  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D33 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] D3  = 128'h0BADF00D_0BADF00D_12345678_9ABCDEF0;
  localparam logic [127:0] D5  = 128'hFEEDFACE_C0FFEE00_13579BDF_2468ACE0;
  localparam logic [127:0] DA  = 128'h000000AA_000000AA_000000AA_000000AA;
  localparam logic [127:0] DB  = 128'h000000BB_000000BB_000000BB_000000BB;
  localparam logic [127:0] D4  = 128'h77777777_77777777_77777777_77777777;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Ticks until BUSY_WAIT is low; n = edges taken (first one is the capture).
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (bus.BUSY_WAIT !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " done reached"}, 128'(bus.BUSY_WAIT), 128'd0);
  endtask

  // One complete request. Read data is compared with the head of exp_q.
  // With hold=1 the request lines are left as they are in DONE.
  task automatic access(input string tag, input bit wr, input bit rd,
                        input logic [27:0] addr, input logic [127:0] wdata,
                        input bit hold, output int n);
    logic [127:0] exp_rd;
    bus.WRITE      = wr;
    bus.READ       = rd;
    bus.ADDRESS    = addr;
    bus.WRITE_DATA = wdata;
    #1;
    check({tag, " busy in request cycle"}, 128'(bus.BUSY_WAIT), 128'd1);
    wait_done(tag, n);
    check({tag, " latency"}, 128'(n - 1), 128'(LAT));
    check({tag, " state done"}, 128'(state_dbg), 128'(DONE));
    exp_rd = '0;
    if (rd) begin
      exp_rd = exp_q.pop_front();
      check({tag, " read data"}, bus.READ_DATA, exp_rd);
    end
    if (!hold) begin
      bus.WRITE = 1'b0;
      bus.READ  = 1'b0;
      tick();
      check({tag, " back to idle"}, 128'(state_dbg), 128'(IDLE));
      check({tag, " busy low in idle"}, 128'(bus.BUSY_WAIT), 128'd0);
      if (rd) check({tag, " read data held"}, bus.READ_DATA, exp_rd);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, m;

    // Reset with a read request pending: stall must stay low.
    RESET          = 1'b1;
    bus.READ       = 1'b1;
    bus.WRITE      = 1'b0;
    bus.ADDRESS    = '0;
    bus.WRITE_DATA = '0;
    #1;
    check("reset busy pre-edge", 128'(bus.BUSY_WAIT), 128'd0);
    tick();
    check("reset busy edge1", 128'(bus.BUSY_WAIT), 128'd0);
    tick();
    check("reset busy edge2", 128'(bus.BUSY_WAIT), 128'd0);
    check("reset read data", bus.READ_DATA, 128'd0);
    check("reset state", 128'(state_dbg), 128'(IDLE));
    bus.READ = 1'b0;
    RESET    = 1'b0;
    tick();
    check("post-reset state", 128'(state_dbg), 128'(IDLE));
    check("post-reset busy", 128'(bus.BUSY_WAIT), 128'd0);

    // Write then read line 5.
    access("wr5", 1'b1, 1'b0, 28'h0000005, D1, 1'b0, n);
    exp_q.push_back(D1);
    access("rd5", 1'b0, 1'b1, 28'h0000005, '0, 1'b0, n);

    // Seed line 0x33, then write-back 0x12 followed by fill 0x33.
    access("wr33", 1'b1, 1'b0, 28'h0000033, D33, 1'b0, n);
    access("wb12", 1'b1, 1'b0, 28'h0000012, D2, 1'b1, n);
    bus.WRITE   = 1'b0;
    bus.READ    = 1'b1;
    bus.ADDRESS = 28'h0000033;
    #1;
    check("b2b no capture in done", 128'(bus.BUSY_WAIT), 128'd0);
    tick();
    check("b2b idle state", 128'(state_dbg), 128'(IDLE));
    check("b2b busy in idle", 128'(bus.BUSY_WAIT), 128'd1);
    wait_done("b2b fill", m);
    check("b2b total edges", 128'((n - 1) + 1 + m), 128'd12);
    check("b2b fill data", bus.READ_DATA, D33);
    bus.READ = 1'b0;
    tick();
    exp_q.push_back(D2);
    access("rd12", 1'b0, 1'b1, 28'h0000012, '0, 1'b0, n);

    // Aliasing: 0x105 and 0x005 share a line.
    access("wr105", 1'b1, 1'b0, 28'h0000105, D3, 1'b0, n);
    exp_q.push_back(D3);
    access("rd005 alias", 1'b0, 1'b1, 28'h0000005, '0, 1'b0, n);

    // READ and WRITE together: write wins, read data untouched.
    exp_q.push_back(D3);
    access("both", 1'b1, 1'b1, 28'h0000040, D5, 1'b0, n);
    exp_q.push_back(D5);
    access("rd40", 1'b0, 1'b1, 28'h0000040, '0, 1'b0, n);

    // Changes after capture are ignored; dropping WRITE does not cancel.
    bus.WRITE      = 1'b1;
    bus.ADDRESS    = 28'h0000020;
    bus.WRITE_DATA = DA;
    tick();
    bus.WRITE      = 1'b0;
    bus.ADDRESS    = 28'h0000021;
    bus.WRITE_DATA = DB;
    wait_done("inflight", n);
    check("inflight latency", 128'(n), 128'(LAT));
    tick();
    exp_q.push_back(DA);
    access("rd20", 1'b0, 1'b1, 28'h0000020, '0, 1'b0, n);
    exp_q.push_back(128'd0);
    access("rd21", 1'b0, 1'b1, 28'h0000021, '0, 1'b0, n);

    // Reset two edges into a write aborts it.
    bus.WRITE      = 1'b1;
    bus.ADDRESS    = 28'h0000007;
    bus.WRITE_DATA = D4;
    tick();
    tick();
    RESET     = 1'b1;
    bus.WRITE = 1'b0;
    #1;
    check("abort busy forced low", 128'(bus.BUSY_WAIT), 128'd0);
    tick();
    RESET = 1'b0;
    #1;
    check("abort state", 128'(state_dbg), 128'(IDLE));
    check("abort busy", 128'(bus.BUSY_WAIT), 128'd0);
    check("abort read data cleared", bus.READ_DATA, 128'd0);
    exp_q.push_back(128'd0);
    access("rd7 after abort", 1'b0, 1'b1, 28'h0000007, '0, 1'b0, n);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
